memory_stage: RTL and testbench

//  MM stage of the 5-stage MIPS pipeline: consumes the EX/MM latch contents, drives the dcache request
//  (load/store/LL/SC), resolves branch mispredicts, owns the LL/SC link register, and registers results

---
 rtl/control_unit_types_pkg.sv | 21 ++
 rtl/cpu_types_pkg.sv | 16 +
 rtl/mmwbpipe_if.sv | 12 +
 rtl/llsc_link.sv | 44 ++++
 rtl/memory_stage.sv | 162 ++++++++++++++++
 tb/tb_memory_stage.sv | 270 +++++++++++++++++++++++++++
 6 files changed

// File: rtl/control_unit_types_pkg.sv
// Decoded-op and writeback-select encodings produced by the control unit.
package control_unit_types_pkg;

  typedef enum logic [3:0] {
    NOP   = 4'h0,
    ALU   = 4'h1,
    LOAD  = 4'h2,
    STORE = 4'h3,
    BEQ   = 4'h4,
    BNE   = 4'h5,
    JUMP  = 4'h6,
    HALT  = 4'h7
  } opfunc_t;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_MEM = 2'd1,
    WB_NPC = 2'd2
  } memtoreg_t;

endpackage

// File: rtl/cpu_types_pkg.sv
// Shared datapath widths and the MM-stage access state type.
package cpu_types_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned REG_W  = 5;

  typedef logic [WORD_W-1:0] word_t;
  typedef logic [REG_W-1:0]  regbits_t;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    HALTED
  } memstate_t;

endpackage

// File: rtl/mmwbpipe_if.sv
// MM/WB pipeline latch contents, bundled for the writeback stage.
interface mmwbpipe_if;

  logic                              regwen;
  control_unit_types_pkg::memtoreg_t memtoreg;
  cpu_types_pkg::regbits_t           rd;
  cpu_types_pkg::word_t              aluout;
  cpu_types_pkg::word_t              dload;
  cpu_types_pkg::word_t              npc;
  logic                              halt;

endinterface

// File: rtl/llsc_link.sv
// LL/SC link register: set by a completed LL, compared by SC, cleared by
// SC completion, a local store to the linked word, or a coherence invalidate.
module llsc_link
  import cpu_types_pkg::*;
(
  input  logic  CLK,
  input  logic  RST,
  input  logic  ll_set,
  input  word_t ll_addr,
  input  word_t sc_addr,
  output logic  sc_ok,
  input  logic  sc_done,
  input  logic  st_done,
  input  word_t st_addr,
  input  logic  ccinv,
  input  word_t ccinvaddr
);

  logic  link_valid;
  word_t link_addr;
  logic  link_clr;

  // Any event that breaks the reservation.
  always_comb begin
    link_clr = sc_done
             | (st_done & (st_addr == link_addr))
             | (ccinv & (ccinvaddr == link_addr));
    sc_ok    = link_valid & (link_addr == sc_addr);
  end

  // Link state; a same-cycle LL beats any clear because its data is newer.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      link_valid <= 1'b0;
      link_addr  <= '0;
    end else if (ll_set) begin
      link_valid <= 1'b1;
      link_addr  <= ll_addr;
    end else if (link_clr) begin
      link_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/memory_stage.sv
// MM stage: dcache request/stall control, LL/SC, branch resolution, MM/WB latch.
module memory_stage
  import cpu_types_pkg::*;
  import control_unit_types_pkg::*;
#(
  parameter int unsigned STALL_CNT_W = 32
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  opfunc_t                mm_opfunc,
  input  memtoreg_t              mm_MemtoReg,
  input  logic                   mm_RegWEN,
  input  logic                   mm_dWENi,
  input  logic                   mm_dRENi,
  input  logic                   mm_datomic,
  input  logic                   mm_equal,
  input  logic                   mm_taken,
  input  logic                   mm_halt,
  input  regbits_t               mm_rd,
  input  word_t                  mm_npc,
  input  word_t                  mm_bpc,
  input  word_t                  mm_ALUOut,
  input  word_t                  mm_store,
  input  logic                   dhit,
  input  word_t                  dmemload,
  input  logic                   ccinv,
  input  word_t                  ccinvaddr,
  output logic                   dmemREN,
  output logic                   dmemWEN,
  output word_t                  dmemaddr,
  output word_t                  dmemstore,
  output logic                   mm_stall,
  output logic                   flush,
  output word_t                  redirect_pc,
  output logic                   wb_RegWEN,
  output memtoreg_t              wb_MemtoReg,
  output regbits_t               wb_rd,
  output word_t                  wb_ALUOut,
  output word_t                  wb_dload,
  output word_t                  wb_npc,
  output logic                   wb_halt,
  output logic                   halt_o,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  memstate_t state_q, state_d;
  logic      halt_q;
  logic [STALL_CNT_W-1:0] stall_cnt_q;

  logic active, is_sc, sc_ok, sc_fail, memop, complete;
  logic ll_set, st_done, br, actual;

  mmwbpipe_if mmwb ();

  // Request/stall decode; RST gates requests so they drop asynchronously.
  always_comb begin
    active   = !RST && !halt_q && (state_q != HALTED);
    is_sc    = mm_dWENi & mm_datomic;
    sc_fail  = is_sc & !sc_ok;
    memop    = (mm_dRENi | mm_dWENi) & !sc_fail;
    dmemREN  = active & memop & mm_dRENi;
    dmemWEN  = active & memop & mm_dWENi;
    mm_stall = active & memop & !dhit;
    complete = active & !mm_stall;
    ll_set   = active & mm_dRENi & mm_datomic & dhit;
    st_done  = active & memop & mm_dWENi & dhit;
  end

  assign dmemaddr  = mm_ALUOut;
  assign dmemstore = mm_store;

  // Branch resolution; a stalled branch waits until it can complete.
  always_comb begin
    br          = (mm_opfunc == BEQ) || (mm_opfunc == BNE);
    actual      = (mm_opfunc == BEQ) ? mm_equal : !mm_equal;
    flush       = br & (actual ^ mm_taken) & !mm_stall;
    redirect_pc = actual ? mm_bpc : mm_npc;
  end

  llsc_link u_llsc_link (
    .CLK       (CLK),
    .RST       (RST),
    .ll_set    (ll_set),
    .ll_addr   (mm_ALUOut),
    .sc_addr   (mm_ALUOut),
    .sc_ok     (sc_ok),
    .sc_done   (complete & is_sc),
    .st_done   (st_done),
    .st_addr   (mm_ALUOut),
    .ccinv     (ccinv),
    .ccinvaddr (ccinvaddr)
  );

  // Next access state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, ACCESS: begin
        if (complete && mm_halt) state_d = HALTED;
        else if (mm_stall)       state_d = ACCESS;
        else                     state_d = IDLE;
      end
      HALTED:  state_d = HALTED;
      default: state_d = IDLE;
    endcase
  end

  // State register and sticky halt.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      halt_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (complete && mm_halt) halt_q <= 1'b1;
    end
  end

  // Saturating count of stall cycles.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      stall_cnt_q <= '0;
    end else if (mm_stall && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end

  // MM/WB latch: capture on completion, bubble while stalled, freeze once halted.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      mmwb.regwen   <= 1'b0;
      mmwb.memtoreg <= WB_ALU;
      mmwb.rd       <= '0;
      mmwb.aluout   <= '0;
      mmwb.dload    <= '0;
      mmwb.npc      <= '0;
      mmwb.halt     <= 1'b0;
    end else if (complete) begin
      mmwb.regwen   <= mm_RegWEN;
      mmwb.memtoreg <= mm_MemtoReg;
      mmwb.rd       <= mm_rd;
      mmwb.aluout   <= is_sc ? word_t'(sc_ok) : mm_ALUOut;
      mmwb.dload    <= dmemload;
      mmwb.npc      <= mm_npc;
      mmwb.halt     <= mm_halt;
    end else if (mm_stall) begin
      mmwb.regwen   <= 1'b0;
      mmwb.halt     <= 1'b0;
    end
  end

  assign wb_RegWEN   = mmwb.regwen;
  assign wb_MemtoReg = mmwb.memtoreg;
  assign wb_rd       = mmwb.rd;
  assign wb_ALUOut   = mmwb.aluout;
  assign wb_dload    = mmwb.dload;
  assign wb_npc      = mmwb.npc;
  assign wb_halt     = mmwb.halt;
  assign halt_o      = halt_q;
  assign stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_memory_stage.sv
// Directed bench for memory_stage: single-cycle vector table plus multi-cycle sequences.
module tb_memory_stage;
  import cpu_types_pkg::*;
  import control_unit_types_pkg::*;

  logic        CLK = 1'b0;
  logic        RST;
  opfunc_t     mm_opfunc;
  memtoreg_t   mm_MemtoReg;
  logic        mm_RegWEN, mm_dWENi, mm_dRENi, mm_datomic, mm_equal, mm_taken, mm_halt;
  regbits_t    mm_rd;
  word_t       mm_npc, mm_bpc, mm_ALUOut, mm_store;
  logic        dhit;
  word_t       dmemload;
  logic        ccinv;
  word_t       ccinvaddr;
  logic        dmemREN, dmemWEN, mm_stall, flush;
  word_t       dmemaddr, dmemstore, redirect_pc;
  logic        wb_RegWEN, wb_halt, halt_o;
  memtoreg_t   wb_MemtoReg;
  regbits_t    wb_rd;
  word_t       wb_ALUOut, wb_dload, wb_npc;
  logic [31:0] stall_cnt;

  int n_vec = 0;
  int n_miss = 0;

  memory_stage #(.STALL_CNT_W(32)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .mm_opfunc   (mm_opfunc),
    .mm_MemtoReg (mm_MemtoReg),
    .mm_RegWEN   (mm_RegWEN),
    .mm_dWENi    (mm_dWENi),
    .mm_dRENi    (mm_dRENi),
    .mm_datomic  (mm_datomic),
    .mm_equal    (mm_equal),
    .mm_taken    (mm_taken),
    .mm_halt     (mm_halt),
    .mm_rd       (mm_rd),
    .mm_npc      (mm_npc),
    .mm_bpc      (mm_bpc),
    .mm_ALUOut   (mm_ALUOut),
    .mm_store    (mm_store),
    .dhit        (dhit),
    .dmemload    (dmemload),
    .ccinv       (ccinv),
    .ccinvaddr   (ccinvaddr),
    .dmemREN     (dmemREN),
    .dmemWEN     (dmemWEN),
    .dmemaddr    (dmemaddr),
    .dmemstore   (dmemstore),
    .mm_stall    (mm_stall),
    .flush       (flush),
    .redirect_pc (redirect_pc),
    .wb_RegWEN   (wb_RegWEN),
    .wb_MemtoReg (wb_MemtoReg),
    .wb_rd       (wb_rd),
    .wb_ALUOut   (wb_ALUOut),
    .wb_dload    (wb_dload),
    .wb_npc      (wb_npc),
    .wb_halt     (wb_halt),
    .halt_o      (halt_o),
    .stall_cnt   (stall_cnt)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    opfunc_t     op;
    logic        ren, wen, atomic, equal, taken, dhit, regwen;
    logic [4:0]  rd;
    logic [31:0] npc, bpc, alu, load;
    logic        x_ren, x_wen, x_stall, x_flush;
    logic [31:0] x_redir, x_alu;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic set_nop();
    mm_opfunc = NOP; mm_MemtoReg = WB_ALU; mm_RegWEN = 0; mm_dWENi = 0; mm_dRENi = 0;
    mm_datomic = 0; mm_equal = 1; mm_taken = 0; mm_halt = 0; mm_rd = 0;
    mm_npc = 0; mm_bpc = 0; mm_ALUOut = 0; mm_store = 0; dhit = 0; dmemload = 0;
    ccinv = 0; ccinvaddr = 0;
  endtask

  // Advance to the next rising edge and sample 1 time unit after it.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive_mem(input opfunc_t op, input logic ren, input logic wen,
                           input logic atom, input logic [31:0] addr, input logic hit);
    set_nop();
    mm_opfunc = op; mm_dRENi = ren; mm_dWENi = wen; mm_datomic = atom;
    mm_ALUOut = addr; dhit = hit;
  endtask

  initial begin
    //          op     rn wn at eq tk dh rw rd  npc    bpc    alu       load
    //          xren xwen xstl xfl  xredir xalu
    vecs[0] = '{ALU,   0, 0, 0, 1, 0, 0, 1, 3, 32'h14, 32'h80, 32'h1234, 32'h0,
                0, 0, 0, 0, 32'h14, 32'h1234};
    vecs[1] = '{LOAD,  1, 0, 0, 1, 0, 1, 1, 5, 32'h18, 32'h80, 32'h200, 32'hdeadbeef,
                1, 0, 0, 0, 32'h18, 32'h200};
    vecs[2] = '{STORE, 0, 1, 0, 1, 0, 1, 0, 0, 32'h1c, 32'h80, 32'h300, 32'h0,
                0, 1, 0, 0, 32'h1c, 32'h300};
    vecs[3] = '{BEQ,   0, 0, 0, 1, 0, 0, 0, 0, 32'h24, 32'h40, 32'h0, 32'h0,
                0, 0, 0, 1, 32'h40, 32'h0};
    vecs[4] = '{BNE,   0, 0, 0, 1, 0, 0, 0, 0, 32'h28, 32'h44, 32'h0, 32'h0,
                0, 0, 0, 0, 32'h28, 32'h0};
    vecs[5] = '{BEQ,   0, 0, 0, 0, 1, 0, 0, 0, 32'h2c, 32'h48, 32'h0, 32'h0,
                0, 0, 0, 1, 32'h2c, 32'h0};
    vecs[6] = '{BNE,   0, 0, 0, 0, 1, 0, 0, 0, 32'h30, 32'h4c, 32'h0, 32'h0,
                0, 0, 0, 0, 32'h4c, 32'h0};
    vecs[7] = '{BEQ,   0, 0, 0, 1, 1, 0, 0, 0, 32'h34, 32'h50, 32'h0, 32'h0,
                0, 0, 0, 0, 32'h50, 32'h0};
    // SC with no reservation: fails in one cycle, no request, result 0.
    vecs[8] = '{STORE, 0, 1, 1, 1, 0, 0, 1, 7, 32'h38, 32'h80, 32'h100, 32'h0,
                0, 0, 0, 0, 32'h38, 32'h0};

    // Reset state, with a load presented to prove requests are gated by RST.
    RST = 1'b1;
    set_nop();
    mm_dRENi = 1;
    #2;
    check("rst.dmemREN", dmemREN, 0);
    check("rst.mm_stall", mm_stall, 0);
    check("rst.wb_RegWEN", wb_RegWEN, 0);
    check("rst.wb_ALUOut", wb_ALUOut, 0);
    check("rst.wb_halt", wb_halt, 0);
    check("rst.halt_o", halt_o, 0);
    check("rst.stall_cnt", stall_cnt, 0);
    set_nop();
    @(posedge CLK);
    #1 RST = 1'b0;

    for (int i = 0; i < 9; i++) begin
      set_nop();
      mm_opfunc = vecs[i].op; mm_dRENi = vecs[i].ren; mm_dWENi = vecs[i].wen;
      mm_datomic = vecs[i].atomic; mm_equal = vecs[i].equal; mm_taken = vecs[i].taken;
      dhit = vecs[i].dhit; mm_RegWEN = vecs[i].regwen; mm_rd = vecs[i].rd;
      mm_npc = vecs[i].npc; mm_bpc = vecs[i].bpc; mm_ALUOut = vecs[i].alu;
      dmemload = vecs[i].load; mm_store = ~vecs[i].alu;
      #3;
      check($sformatf("v%0d.dmemREN", i), dmemREN, vecs[i].x_ren);
      check($sformatf("v%0d.dmemWEN", i), dmemWEN, vecs[i].x_wen);
      check($sformatf("v%0d.mm_stall", i), mm_stall, vecs[i].x_stall);
      check($sformatf("v%0d.flush", i), flush, vecs[i].x_flush);
      check($sformatf("v%0d.redirect_pc", i), redirect_pc, vecs[i].x_redir);
      check($sformatf("v%0d.dmemaddr", i), dmemaddr, vecs[i].alu);
      tick();
      check($sformatf("v%0d.wb_ALUOut", i), wb_ALUOut, vecs[i].x_alu);
      check($sformatf("v%0d.wb_RegWEN", i), wb_RegWEN, vecs[i].regwen);
      check($sformatf("v%0d.wb_rd", i), wb_rd, vecs[i].rd);
      check($sformatf("v%0d.wb_dload", i), wb_dload, vecs[i].load);
    end

    // LW that misses for three cycles.
    drive_mem(LOAD, 1, 0, 0, 32'h80, 0);
    mm_RegWEN = 1; mm_rd = 9;
    for (int i = 0; i < 3; i++) begin
      #3;
      check($sformatf("lw.stall%0d", i), mm_stall, 1);
      check($sformatf("lw.ren%0d", i), dmemREN, 1);
      check($sformatf("lw.flush%0d", i), flush, 0);
      tick();
      check($sformatf("lw.bubble%0d", i), wb_RegWEN, 0);
    end
    dhit = 1; dmemload = 32'hcafef00d;
    #3;
    check("lw.stall_done", mm_stall, 0);
    check("lw.ren_done", dmemREN, 1);
    tick();
    check("lw.wb_RegWEN", wb_RegWEN, 1);
    check("lw.wb_dload", wb_dload, 32'hcafef00d);
    check("lw.wb_rd", wb_rd, 9);
    check("lw.stall_cnt", stall_cnt, 3);

    // LL then SC succeeds; a repeated SC fails.
    drive_mem(LOAD, 1, 0, 1, 32'h100, 1);
    tick();
    drive_mem(STORE, 0, 1, 1, 32'h100, 1);
    #3;
    check("sc1.dmemWEN", dmemWEN, 1);
    check("sc1.stall", mm_stall, 0);
    tick();
    check("sc1.wb_ALUOut", wb_ALUOut, 1);
    #3;
    check("sc2.dmemWEN", dmemWEN, 0);
    check("sc2.stall", mm_stall, 0);
    tick();
    check("sc2.wb_ALUOut", wb_ALUOut, 0);

    // LL, coherence invalidate of the linked word, then SC fails without a request.
    drive_mem(LOAD, 1, 0, 1, 32'h100, 1);
    tick();
    set_nop();
    mm_ALUOut = 32'h77; ccinv = 1; ccinvaddr = 32'h100;
    tick();
    check("inv.wb_ALUOut_nop", wb_ALUOut, 32'h77);
    drive_mem(STORE, 0, 1, 1, 32'h100, 0);
    #3;
    check("inv.dmemWEN", dmemWEN, 0);
    check("inv.stall", mm_stall, 0);
    tick();
    check("inv.wb_ALUOut", wb_ALUOut, 0);
    check("inv.stall_cnt", stall_cnt, 3);

    // LL and matching invalidate in the same cycle: the LL's reservation survives.
    drive_mem(LOAD, 1, 0, 1, 32'h100, 1);
    ccinv = 1; ccinvaddr = 32'h100;
    tick();
    drive_mem(STORE, 0, 1, 1, 32'h100, 1);
    #3;
    check("llinv.dmemWEN", dmemWEN, 1);
    tick();
    check("llinv.wb_ALUOut", wb_ALUOut, 1);

    // HALT, then a later load must not reach the dcache.
    set_nop();
    mm_halt = 1; mm_ALUOut = 32'h55;
    tick();
    check("halt.wb_halt", wb_halt, 1);
    check("halt.halt_o", halt_o, 1);
    drive_mem(LOAD, 1, 0, 0, 32'h200, 0);
    #3;
    check("halt.dmemREN", dmemREN, 0);
    check("halt.stall", mm_stall, 0);
    tick();
    check("halt.wb_ALUOut_hold", wb_ALUOut, 32'h55);
    check("halt.halt_o_sticky", halt_o, 1);

    // Reset pulse clears halt; then reset mid-ACCESS drops the request at once.
    RST = 1'b1;
    tick();
    RST = 1'b0;
    check("rst2.halt_o", halt_o, 0);
    drive_mem(LOAD, 1, 0, 0, 32'h240, 0);
    mm_RegWEN = 1; mm_halt = 0;
    #3;
    check("acc.ren", dmemREN, 1);
    check("acc.stall", mm_stall, 1);
    tick();
    check("acc.stall_cnt", stall_cnt, 1);
    #2 RST = 1'b1;
    #1;
    check("accrst.dmemREN", dmemREN, 0);
    check("accrst.stall", mm_stall, 0);
    check("accrst.wb_RegWEN", wb_RegWEN, 0);
    check("accrst.wb_ALUOut", wb_ALUOut, 0);
    check("accrst.wb_npc", wb_npc, 0);
    check("accrst.stall_cnt", stall_cnt, 0);
    tick();
    RST = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
